// File: rtl/lz_normalizer_if.sv
// Request/response bundle for the iterative leading-zero normalizer.
// The master issues requests and consumes results; the slave is the unit.
interface lz_normalizer_if #(
    parameter int XLEN = 32
);
    localparam int CW = $clog2(XLEN) + 1;

    logic            in_valid;
    logic            in_ready;
    logic            in_op;
    logic [XLEN-1:0] in_data;
    logic [CW-1:0]   in_count;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;
    logic [CW-1:0]   out_count;
    logic            out_zero;

    modport master (
        output in_valid, in_op, in_data, in_count, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_zero
    );

    modport slave (
        input  in_valid, in_op, in_data, in_count, out_ready,
        output in_ready, out_valid, out_data, out_count, out_zero
    );
endinterface

// File: rtl/lz_normalizer.sv
// Iterative NORM (left-justify + leading-zero count) / DENORM (logical right
// shift by count), one count bit per cycle, MSB first, fixed L+1 cycle latency.
module lz_normalizer #(
    parameter int XLEN = 32
) (
    input logic             clk,
    input logic             rst,
    lz_normalizer_if.slave  bus
);
    localparam int L  = $clog2(XLEN);
    localparam int CW = L + 1;
    localparam int KW = $clog2(L);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic            op_q;
    logic [XLEN-1:0] work_q;
    logic [CW-1:0]   cnt_q;
    logic [L-1:0]    acc_q;
    logic [KW-1:0]   k_q;
    logic            out_valid_q;
    logic [XLEN-1:0] out_data_q;
    logic [CW-1:0]   out_count_q;
    logic            out_zero_q;

    logic [CW-1:0]   shamt;
    logic [XLEN-1:0] ones;
    logic [XLEN-1:0] top_mask;
    logic [XLEN-1:0] work_d;
    logic [L-1:0]    acc_d;
    logic [XLEN-1:0] final_data;
    logic [CW-1:0]   final_count;

    always_comb begin
        shamt    = CW'(1) << k_q;
        ones     = '1;
        top_mask = ~(ones >> shamt);
        work_d   = work_q;
        acc_d    = acc_q;
        if (!op_q) begin
            if ((work_q & top_mask) == '0) begin
                work_d = work_q << shamt;
                acc_d  = acc_q | (L'(1) << k_q);
            end
        end else if (cnt_q[k_q]) begin
            work_d = work_q >> shamt;
        end
        // A zero NORM operand sets every accumulator bit; report XLEN instead.
        // DENORM counts >= XLEN flush regardless of the low count bits.
        final_data = (op_q && cnt_q[CW-1]) ? '0 : work_d;
        if (op_q)
            final_count = cnt_q;
        else if (work_d == '0)
            final_count = CW'(XLEN);
        else
            final_count = {1'b0, acc_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= 1'b0;
            work_q      <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q    <= bus.in_op;
                        work_q  <= bus.in_data;
                        cnt_q   <= bus.in_count;
                        acc_q   <= '0;
                        k_q     <= KW'(L - 1);
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    work_q <= work_d;
                    acc_q  <= acc_d;
                    if (k_q == '0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        out_data_q  <= final_data;
                        out_count_q <= final_count;
                        out_zero_q  <= (final_data == '0);
                    end else begin
                        k_q <= k_q - KW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;
    assign bus.out_zero  = out_zero_q;
endmodule
